bcd_seg7_scan: RTL and testbench
================================

// Module: bcd_seg7_scan
// PURPOSE
//  Time-multiplexed 3-digit 7-segment display driver that consumes the packed BCD digits
//  (hundreds/tens/ones) produced by the binary-to-BCD converter.
//  - Double-buffers each new value and applies it only at a frame boundary, so no torn digits.
//  - Scans one digit per refresh slot, with leading-zero blanking, an anti-ghost guard
//    interval and selectable output polarity.
// PARAMETERS
//  REFRESH_DIV   50000  clock cycles per digit slot (>=2)
//  GUARD         2      cycles at start of each slot with all anodes off (0..REFRESH_DIV-1)
//  BLANK_LEADING 1      1 = blank leading zeros of hundreds/tens; 0 = always show all digits
//  ACTIVE_LOW    1      1 = seg/an are active-low (0 lights); 0 = active-high
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  synchronous reset, active-low
//  in_valid    in   1  1-cycle strobe: capture hundreds/tens/ones into pending buffer
//  hundreds    in   4  BCD hundreds digit
//  tens        in   4  BCD tens digit
//  ones        in   4  BCD ones digit
//  seg         out  7  segments {g,f,e,d,c,b,a}, seg[0]=a
//  an          out  3  digit enables; an[0]=ones, an[1]=tens, an[2]=hundreds
//  frame_done  out  1  1-cycle pulse when a full 3-digit scan completes
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all state is cleared.
//    - prescaler=0, idx=0, pending regs=0, pend_flag=0, display regs=0, frame_done=0.
//    - seg and an are driven fully off: 7'h7F / 3'b111 if ACTIVE_LOW, otherwise 0.
//    - Reset mid-scan or mid-update discards any pending value.
//  - Prescaler: counts 0..REFRESH_DIV-1 and wraps; tick = (prescaler==REFRESH_DIV-1).
//  - Digit index idx advances 0->1->2->0 on tick.
//  - Frame boundary = tick with idx==2; frame_done is registered and high the cycle after.
//  - in_valid: pending <= {hundreds,tens,ones}, pend_flag <= 1. A later in_valid before the
//    boundary overwrites pending (last value wins).
//  - At frame boundary, if pend_flag: display <= pending, pend_flag <= 0.
//    - If in_valid coincides with the boundary, display takes the old pending contents.
//    - The new value goes to pending with pend_flag=1 and is shown one frame later.
//  - Decode, active-high form:
//    - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//    - Non-BCD 10..15 = 40 (dash, g only).
//  - Blanking (BLANK_LEADING=1):
//    - hundreds slot blank if disp_h==0.
//    - tens slot blank if disp_h==0 && disp_t==0.
//    - ones slot never blanked.
//    - Blank slot = anode off, seg off.
//  - Guard: while prescaler<GUARD, an is all off and seg is off.
//  - Outputs seg/an are registered: they reflect idx/prescaler/display of the previous cycle
//    (1-cycle latency). Exactly one anode is on at a time, never more.
//  - ACTIVE_LOW inverts seg and an after decode; frame_done is always active-high.
// TESTING
//  Bench parameters: REFRESH_DIV=4, GUARD=1, BLANK_LEADING=1, ACTIVE_LOW=1.
//  1. Reset held 3 cycles -> an=3'b111, seg=7'h7F, frame_done=0. After release, ones slot
//     shows seg=~7'h3F ("0"); tens and hundreds slots stay dark.
//  2. in_valid with 1/2/3, wait one boundary -> slots show ~4F on an=110, ~5B on an=101,
//     ~06 on an=011; each slot has a 1-cycle all-off guard; frame_done pulses every 12 cycles.
//  3. Load 0/0/5 -> only an[0] ever asserted, seg=~6D. Load 0/4/0 -> tens ~66, ones ~3F,
//     hundreds dark.
//  4. Display 123; in_valid 2/5/5 while idx=1 -> 123 persists to frame end, 255 from the
//     next frame. Two in_valids in one frame -> only the last is displayed.
//  5. in_valid coincident with boundary tick -> new value appears one frame later, not
//     immediately. Digit 4'hC -> seg=~7'h40 in that slot.
//  6. rst_n low for 1 cycle mid-slot with pending data -> next cycle all outputs off and
//     counters 0; the pending value is never displayed.

Source files
------------

// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed 3-digit 7-segment driver with frame-synchronous double buffering,
// leading-zero blanking, an anti-ghost guard interval and selectable output polarity.
module bcd_seg7_scan #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 2,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_LIM  = PW'(GUARD);
  localparam logic [6:0]    SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0]    AN_OFF     = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   pend_q, pend_d;
  logic          pend_flag_q, pend_flag_d;
  logic [11:0]   disp_q, disp_d;
  logic          frame_done_q, frame_done_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    digit;
  logic          blank;
  logic          guard_on;
  logic [6:0]    seg_act;
  logic [2:0]    an_act;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign tick     = (presc_q == PRESC_LAST);
  assign boundary = tick && (idx_q == 2'd2);

  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    pend_d       = pend_q;
    pend_flag_d  = pend_flag_q;
    disp_d       = disp_q;
    frame_done_d = boundary;

    if (tick) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    // Display latches the buffer as it stood before this edge; a coincident
    // in_valid therefore lands in pending and waits a full frame.
    if (boundary && pend_flag_q) begin
      disp_d      = pend_q;
      pend_flag_d = 1'b0;
    end
    if (in_valid) begin
      pend_d      = {hundreds, tens, ones};
      pend_flag_d = 1'b1;
    end
  end

  always_comb begin
    digit = disp_q[3:0];
    blank = 1'b0;
    an_act = 3'b000;
    case (idx_q)
      2'd0: begin
        digit  = disp_q[3:0];
        an_act = 3'b001;
      end
      2'd1: begin
        digit  = disp_q[7:4];
        an_act = 3'b010;
        blank  = (BLANK_LEADING != 0) && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
      end
      2'd2: begin
        digit  = disp_q[11:8];
        an_act = 3'b100;
        blank  = (BLANK_LEADING != 0) && (disp_q[11:8] == 4'd0);
      end
      default: begin
        blank = 1'b1;
      end
    endcase

    guard_on = (presc_q < GUARD_LIM);
    seg_act  = (blank || guard_on) ? 7'h00 : decode(digit);
    if (blank || guard_on) begin
      an_act = 3'b000;
    end

    seg_d = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    an_d  = (ACTIVE_LOW != 0) ? ~an_act : an_act;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      pend_q       <= 12'd0;
      pend_flag_q  <= 1'b0;
      disp_q       <= 12'd0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_flag_q  <= pend_flag_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Scoreboard bench for bcd_seg7_scan: a time-based display model predicts every cycle's
// outputs, and an independent monitor compares them against the DUT.
module tb_bcd_seg7_scan;

  localparam int REFRESH_DIV   = 4;
  localparam int GUARD         = 1;
  localparam int BLANK_LEADING = 1;
  localparam int ACTIVE_LOW    = 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] an;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  // Model state: cycles elapsed since reset plus the digit buffers
  int         t_model;
  logic [3:0] m_disp[3];
  logic [3:0] m_pend[3];
  bit         m_pflag;

  bcd_seg7_scan #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD        (GUARD),
    .BLANK_LEADING(BLANK_LEADING),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] tbl[10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d <= 4'd9) ? tbl[d] : 7'h40;
  endfunction

  // Model index 0 = hundreds, 1 = tens, 2 = ones
  function automatic exp_t predict(input bit in_reset);
    exp_t e;
    int slot, pos;
    bit lit;
    logic [6:0] s;
    logic [2:0] a;
    if (in_reset) begin
      e.seg = 7'h7F;
      e.an  = 3'b111;
      e.fd  = 1'b0;
      return e;
    end
    pos  = t_model % REFRESH_DIV;
    slot = (t_model / REFRESH_DIV) % 3;
    lit  = (pos >= GUARD);
    if (slot == 2 && m_disp[0] == 0) lit = 0;
    if (slot == 1 && m_disp[0] == 0 && m_disp[1] == 0) lit = 0;
    s = lit ? glyph(m_disp[2 - slot]) : 7'h00;
    a = lit ? 3'(1 << slot) : 3'b000;
    e.seg = ~s;
    e.an  = ~a;
    e.fd  = (t_model % (3 * REFRESH_DIV)) == (3 * REFRESH_DIV - 1);
    return e;
  endfunction

  function automatic void advance(input bit in_reset, input bit v,
                                  input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bit at_boundary;
    if (in_reset) begin
      t_model = 0;
      m_disp  = '{4'd0, 4'd0, 4'd0};
      m_pend  = '{4'd0, 4'd0, 4'd0};
      m_pflag = 0;
      return;
    end
    at_boundary = (t_model % (3 * REFRESH_DIV)) == (3 * REFRESH_DIV - 1);
    if (at_boundary && m_pflag) begin
      m_disp  = m_pend;
      m_pflag = 0;
    end
    if (v) begin
      m_pend  = '{h, t, o};
      m_pflag = 1;
    end
    t_model++;
  endfunction

  // One clock of stimulus: drive inputs away from the edge and queue the prediction
  task automatic applyStimulus(input bit rst, input bit v,
                               input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    rst_n    = ~rst;
    in_valid = v;
    hundreds = h;
    tens     = t;
    ones     = o;
    exp_q.push_back(predict(rst));
    advance(rst, v, h, t, o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    applyStimulus(0, 1, h, t, o);
  endtask

  task automatic wait_model(input int phase);
    for (int i = 0; i < 3 * REFRESH_DIV && (t_model % (3 * REFRESH_DIV)) != phase; i++)
      idle(1);
  endtask

  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (seg !== e.seg || an !== e.an || frame_done !== e.fd) begin
      n_fail++;
      $display("[TB] FAIL outputs @%0t: got seg=%h an=%b fd=%b, expected seg=%h an=%b fd=%b",
               $time, seg, an, frame_done, e.seg, e.an, e.fd);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected stimulus to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    hundreds = 4'd0;
    tens     = 4'd0;
    ones     = 4'd0;
    t_model  = 0;
    m_disp   = '{4'd0, 4'd0, 4'd0};
    m_pend   = '{4'd0, 4'd0, 4'd0};
    m_pflag  = 0;

    repeat (3) applyStimulus(1, 0, 4'd0, 4'd0, 4'd0);
    idle(24);

    load(4'd1, 4'd2, 4'd3);
    idle(36);

    load(4'd0, 4'd0, 4'd5);
    idle(36);
    load(4'd0, 4'd4, 4'd0);
    idle(36);

    load(4'd1, 4'd2, 4'd3);
    idle(24);
    wait_model(REFRESH_DIV + 1);
    load(4'd2, 4'd5, 4'd5);
    idle(36);

    wait_model(0);
    load(4'd7, 4'd8, 4'd9);
    idle(3);
    load(4'd3, 4'd0, 4'd6);
    idle(36);

    wait_model(3 * REFRESH_DIV - 1);
    load(4'hC, 4'd4, 4'd1);
    idle(36);

    load(4'd9, 4'd9, 4'd9);
    idle(2);
    applyStimulus(1, 0, 4'd0, 4'd0, 4'd0);
    idle(36);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7) == 0)
        load(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      else if ($urandom_range(99) == 0)
        applyStimulus(1, 0, 4'd0, 4'd0, 4'd0);
      else
        idle(1);
    end
    idle(2);
    stim_done = 1;

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
